// File: rtl/sum_acc_pkg.sv
// Shared types and widths for the sum accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, accumulator width (16) and sample width (9,
// i.e. 8-bit adder result plus carry).
package sum_acc_pkg;

  localparam int ACC_W    = 16;
  localparam int SAMPLE_W = 9;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    OUT_LO = 2'd1,
    OUT_HI = 2'd2
  } acc_state_t;

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Saturating adder: ACC_W-bit accumulator plus zero-extended SAMPLE_W-bit sample.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   acc    in  ACC_W     current accumulator value
//   sample in  SAMPLE_W  unsigned sample to add
//   sum    out ACC_W     acc + sample, clamped to all-ones
//   sat    out 1         the unclamped sum did not fit in ACC_W bits
module sat_add
  import sum_acc_pkg::*;
(
  input  logic [ACC_W-1:0]    acc,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [ACC_W-1:0]    sum,
  output logic                sat
);

  // One extra bit of headroom; the carry out of the top bit is the overflow.
  logic [ACC_W:0] raw_sum;

  assign raw_sum = {1'b0, acc} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, sample};
  assign sat     = raw_sum[ACC_W];
  assign sum     = sat ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates 9-bit sums of a frame into a saturating 16-bit total, then emits it as two bytes.
// Latency: low byte valid the cycle after the last sample is accepted; high byte one handshake later.
// Backpressure: in_ready drops for the whole output phase; output bytes hold until out_ready.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; sample is {in_carry, in_data}
//   in_data, in_carry     adder result byte and carry
//   in_last               sample closes the frame (and is included in the total)
//   out_valid/out_ready   downstream handshake
//   out_data, out_last    total low byte then high byte; out_last marks the high byte
//   count                 samples accepted this frame, saturating at all-ones
//   ovf                   sticky: this frame's total saturated
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  acc_state_t          state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    count_q;
  logic                ovf_q;

  logic [SAMPLE_W-1:0] sample;
  logic [ACC_W-1:0]    acc_next;
  logic                acc_sat;
  logic                accept;

  assign sample = {in_carry, in_data};
  assign accept = in_valid & in_ready;

  sat_add u_sat_add (
    .acc    (acc_q),
    .sample (sample),
    .sum    (acc_next),
    .sat    (acc_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_next;
            // Once saturated acc is all-ones, so any further add re-saturates
            // and the flag simply stays set.
            ovf_q <= ovf_q | acc_sat;
            if (count_q != CNT_MAX) begin
              count_q <= count_q + CNT_ONE;
            end
            if (in_last) begin
              state_q <= OUT_LO;
            end
          end
        end
        OUT_LO: begin
          if (out_ready) begin
            state_q <= OUT_HI;
          end
        end
        OUT_HI: begin
          // Frame fully delivered: start the next one from a clean slate.
          if (out_ready) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  // Outputs decode only from registered state, so there is no
  // combinational path from any input to any output.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
      end
      OUT_LO: begin
        out_valid = 1'b1;
        out_data  = acc_q[7:0];
      end
      OUT_HI: begin
        out_valid = 1'b1;
        out_data  = acc_q[15:8];
        out_last  = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule
